// File: rtl/generic_dac_streamer_pkg.sv
// Shared constants for the DAC waveform streamer: CSR field encodings,
// default geometry and the row-pointer wrap helper.
package generic_dac_streamer_pkg;

    localparam int DEF_BUS_WIDTH         = 32;
    localparam int DEF_AXIS_DATA_WIDTH   = 256;
    localparam int DEF_DAC_DATA_WIDTH    = 16;
    localparam int DEF_DAC_ADDRESS_WIDTH = 14;

    localparam logic [31:0] GPIO_BANK       = 32'h8000_0000;
    localparam logic [31:0] GPIO_RUN        = 32'h0000_0001;
    localparam logic [31:0] ADDRESS_MASK    = 32'h00FF_FFFF;
    localparam logic [31:0] LAST_INDEX_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] SYNCED          = 32'h0000_0002;
    localparam logic [31:0] RUN             = 32'h0000_0001;

    function automatic int unsigned row_advance(input int unsigned row, input int unsigned last_row);
        if (row >= last_row) begin
            return 32'd0;
        end else begin
            return row + 32'd1;
        end
    endfunction

endpackage

// File: rtl/generic_dac_streamer_if.sv
// CSR and AXI-stream signal bundle of the DAC streamer; slave is the streamer side.
interface generic_dac_streamer_if
    import generic_dac_streamer_pkg::*;
#(
    parameter int BUS_WIDTH       = DEF_BUS_WIDTH,
    parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH
);
    logic [BUS_WIDTH-1:0]       sysGpioData;
    logic                       sysGpioStrobe;
    logic                       sysAddressStrobe;
    logic [BUS_WIDTH-1:0]       sysGpioCsr;
    logic                       evrHbMarker;
    logic [AXIS_DATA_WIDTH-1:0] axis_TDATA;
    logic                       axis_TVALID;
    logic                       axis_TREADY;

    modport master (
        output sysGpioData, sysGpioStrobe, sysAddressStrobe, evrHbMarker, axis_TREADY,
        input  sysGpioCsr, axis_TDATA, axis_TVALID
    );

    modport slave (
        input  sysGpioData, sysGpioStrobe, sysAddressStrobe, evrHbMarker, axis_TREADY,
        output sysGpioCsr, axis_TDATA, axis_TVALID
    );
endinterface

// File: rtl/generic_dac_streamer_dac_table_ram.sv
// Waveform table: one sample written per cycle, one full row of SPC samples
// read per cycle with a registered (read-first) output.
module dac_table_ram #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDRESS_WIDTH     = 14,
    parameter int SPC               = 16,
    parameter int ROW_BITS          = 4,
    parameter int ROW_ADDRESS_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDRESS_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [ROW_ADDRESS_WIDTH-1:0]  rd_row,
    output logic [SPC*DATA_WIDTH-1:0]     rd_data
);
    localparam int ROWS = 2 ** ROW_ADDRESS_WIDTH;

    logic [SPC-1:0][DATA_WIDTH-1:0] mem_r [ROWS];

    // sample write into its row lane; lowest address occupies the row LSBs
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr[ADDRESS_WIDTH-1:ROW_BITS]][wr_addr[ROW_BITS-1:0]] <= wr_data;
        end
    end

    // registered row read
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_row];
    end

endmodule

// File: rtl/generic_dac_streamer.sv
// Streams a CSR-loaded sample table onto AXI-stream, one row per beat,
// started and re-aligned to row 0 by the event-receiver heartbeat.
module generic_dac_streamer
    import generic_dac_streamer_pkg::*;
#(
    parameter int BUS_WIDTH         = DEF_BUS_WIDTH,
    parameter int AXIS_DATA_WIDTH   = DEF_AXIS_DATA_WIDTH,
    parameter int DAC_DATA_WIDTH    = DEF_DAC_DATA_WIDTH,
    parameter int DAC_ADDRESS_WIDTH = DEF_DAC_ADDRESS_WIDTH,
    parameter int SPC               = AXIS_DATA_WIDTH / DAC_DATA_WIDTH
) (
    input  logic                  sysClk,
    input  logic                  sysRst_n,
    generic_dac_streamer_if.slave bus
);
    localparam int ROW_BITS = $clog2(SPC);
    localparam int ROW_AW   = DAC_ADDRESS_WIDTH - ROW_BITS;

    logic                         run_r;
    logic                         synced_r;
    logic                         resync_r;
    logic                         tvalid_r;
    logic [DAC_ADDRESS_WIDTH-1:0] addr_r;
    logic [DAC_ADDRESS_WIDTH-1:0] last_index_r;
    logic [ROW_AW-1:0]            nxt_row_r;
    logic [AXIS_DATA_WIDTH-1:0]   tdata_r;

    logic [31:0]                  wr_word_s;
    logic                         gpio_bank_s;
    logic                         run_nxt_s;
    logic                         tbl_we_s;
    logic                         hs_s;
    logic [ROW_AW-1:0]            last_row_s;
    logic [AXIS_DATA_WIDTH-1:0]   rd_data_s;
    logic                         synced_nxt_s;
    logic                         resync_nxt_s;
    logic                         tvalid_nxt_s;
    logic [AXIS_DATA_WIDTH-1:0]   tdata_nxt_s;
    logic [ROW_AW-1:0]            nxt_row_nxt_s;
    logic [31:0]                  csr_word_s;

    assign wr_word_s   = 32'(bus.sysGpioData);
    assign gpio_bank_s = (wr_word_s & GPIO_BANK) != 32'd0;
    assign hs_s        = tvalid_r && bus.axis_TREADY;
    assign last_row_s  = last_index_r[DAC_ADDRESS_WIDTH-1:ROW_BITS];

    // CSR strobe decode: GPIO bank updates run, address bank writes the table
    always_comb begin
        run_nxt_s = run_r;
        tbl_we_s  = 1'b0;
        if (bus.sysGpioStrobe && gpio_bank_s) begin
            run_nxt_s = (wr_word_s & GPIO_RUN) != 32'd0;
        end else if (bus.sysGpioStrobe) begin
            tbl_we_s = sysRst_n;
        end else begin
            tbl_we_s = 1'b0;
        end
    end

    // The table is read every cycle at the row that will be loaded next, so a
    // handshake can always refill TDATA; a heartbeat that lands on a handshake
    // inserts one bubble so row 0 follows the accepted beat.
    always_comb begin
        synced_nxt_s  = synced_r;
        resync_nxt_s  = resync_r;
        tvalid_nxt_s  = tvalid_r;
        tdata_nxt_s   = tdata_r;
        nxt_row_nxt_s = nxt_row_r;
        if (!run_nxt_s) begin
            synced_nxt_s  = 1'b0;
            resync_nxt_s  = 1'b0;
            tvalid_nxt_s  = 1'b0;
            tdata_nxt_s   = {AXIS_DATA_WIDTH{1'b0}};
            nxt_row_nxt_s = {ROW_AW{1'b0}};
        end else if (bus.evrHbMarker && run_r) begin
            synced_nxt_s  = 1'b1;
            resync_nxt_s  = 1'b1;
            nxt_row_nxt_s = {ROW_AW{1'b0}};
            if (hs_s) begin
                tvalid_nxt_s = 1'b0;
                tdata_nxt_s  = {AXIS_DATA_WIDTH{1'b0}};
            end else begin
                tvalid_nxt_s = tvalid_r;
            end
        end else if (synced_r && (!tvalid_r || hs_s)) begin
            tvalid_nxt_s  = 1'b1;
            tdata_nxt_s   = rd_data_s;
            resync_nxt_s  = 1'b0;
            nxt_row_nxt_s = ROW_AW'(row_advance(32'(nxt_row_r), 32'(last_row_s)));
        end else begin
            tvalid_nxt_s = tvalid_r;
        end
    end

    // control and stream registers
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            run_r        <= 1'b0;
            synced_r     <= 1'b0;
            resync_r     <= 1'b0;
            tvalid_r     <= 1'b0;
            addr_r       <= {DAC_ADDRESS_WIDTH{1'b0}};
            last_index_r <= {DAC_ADDRESS_WIDTH{1'b0}};
            nxt_row_r    <= {ROW_AW{1'b0}};
            tdata_r      <= {AXIS_DATA_WIDTH{1'b0}};
        end else begin
            if (bus.sysAddressStrobe) begin
                addr_r <= DAC_ADDRESS_WIDTH'(wr_word_s & ADDRESS_MASK);
            end
            if (tbl_we_s) begin
                last_index_r <= addr_r;
            end
            run_r     <= run_nxt_s;
            synced_r  <= synced_nxt_s;
            resync_r  <= resync_nxt_s;
            tvalid_r  <= tvalid_nxt_s;
            tdata_r   <= tdata_nxt_s;
            nxt_row_r <= nxt_row_nxt_s;
        end
    end

    dac_table_ram #(
        .DATA_WIDTH        (DAC_DATA_WIDTH),
        .ADDRESS_WIDTH     (DAC_ADDRESS_WIDTH),
        .SPC               (SPC),
        .ROW_BITS          (ROW_BITS),
        .ROW_ADDRESS_WIDTH (ROW_AW)
    ) u_table (
        .clk     (sysClk),
        .wr_en   (tbl_we_s),
        .wr_addr (addr_r),
        .wr_data (bus.sysGpioData[DAC_DATA_WIDTH-1:0]),
        .rd_row  (nxt_row_nxt_s),
        .rd_data (rd_data_s)
    );

    // status word assembly
    always_comb begin
        csr_word_s = (32'(last_index_r) << 4'd8) & LAST_INDEX_MASK;
        if (synced_r) begin
            csr_word_s = csr_word_s | SYNCED;
        end else begin
            csr_word_s = csr_word_s;
        end
        if (run_r) begin
            csr_word_s = csr_word_s | RUN;
        end else begin
            csr_word_s = csr_word_s;
        end
    end

    assign bus.sysGpioCsr  = BUS_WIDTH'(csr_word_s);
    assign bus.axis_TDATA  = tdata_r;
    assign bus.axis_TVALID = tvalid_r;

endmodule

// File: tb/tb_generic_dac_streamer.sv
// Self-checking bench for generic_dac_streamer: expected beats are queued from
// a table model as the stream is started/resynced and popped on each handshake.
module tb_generic_dac_streamer;
    import generic_dac_streamer_pkg::*;

    localparam int BW  = 32;
    localparam int XW  = 256;
    localparam int DW  = 16;
    localparam int AW  = 14;
    localparam int SPC = 16;

    logic sysClk   = 1'b0;
    logic sysRst_n = 1'b0;

    generic_dac_streamer_if #(.BUS_WIDTH(BW), .AXIS_DATA_WIDTH(XW)) bus_if ();

    generic_dac_streamer #(
        .BUS_WIDTH         (BW),
        .AXIS_DATA_WIDTH   (XW),
        .DAC_DATA_WIDTH    (DW),
        .DAC_ADDRESS_WIDTH (AW)
    ) dut (
        .sysClk   (sysClk),
        .sysRst_n (sysRst_n),
        .bus      (bus_if)
    );

    always #5 sysClk = ~sysClk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_mem [0:127];
    int            model_addr = 0;
    int            model_last = 0;
    int            push_row   = 0;
    logic [XW-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    function automatic logic [XW-1:0] row_word(input int r);
        logic [XW-1:0] w;
        w = '0;
        for (int k = 0; k < SPC; k++) begin
            w[k*DW +: DW] = model_mem[r*SPC + k];
        end
        return w;
    endfunction

    task automatic csr_addr(input int a);
        bus_if.sysGpioData      = 32'(a);
        bus_if.sysAddressStrobe = 1'b1;
        tick();
        bus_if.sysAddressStrobe = 1'b0;
        model_addr = a;
    endtask

    task automatic csr_write(input logic [31:0] d);
        bus_if.sysGpioData   = d;
        bus_if.sysGpioStrobe = 1'b1;
        tick();
        bus_if.sysGpioStrobe = 1'b0;
        if (d[31] == 1'b0) begin
            model_mem[model_addr] = d[DW-1:0];
            model_last = model_addr;
        end
    endtask

    task automatic tbl_write(input int a, input logic [DW-1:0] v);
        csr_addr(a);
        csr_write({16'h0000, v});
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(row_word(push_row));
            push_row = (push_row >= (model_last >> 4)) ? 0 : push_row + 1;
        end
    endtask

    task automatic start_stream();
        bus_if.axis_TREADY = 1'b1;
        bus_if.evrHbMarker = 1'b1;
        tick();
        bus_if.evrHbMarker = 1'b0;
        check_eq("tvalid_lat1", XW'(bus_if.axis_TVALID), XW'(1'b0));
        tick();
        check_eq("tvalid_lat2", XW'(bus_if.axis_TVALID), XW'(1'b1));
        exp_q.delete();
        push_row = 0;
        refill();
    endtask

    task automatic run_stream(input int ncyc, input int stall_period, input int hb_period);
        int n_beats;
        n_beats = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic          hs;
            logic          stalled;
            logic [XW-1:0] held;
            logic [XW-1:0] front;
            bus_if.axis_TREADY = !(stall_period != 0 && (c % stall_period) == stall_period - 1);
            bus_if.evrHbMarker = (hb_period != 0 && (c % hb_period) == hb_period - 1);
            hs = bus_if.axis_TVALID && bus_if.axis_TREADY;
            if (hs) begin
                n_beats++;
                check_eq("beat", bus_if.axis_TDATA, exp_q.pop_front());
            end
            if (bus_if.evrHbMarker) begin
                if (hs) begin
                    exp_q.delete();
                end else begin
                    front = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(front);
                end
                push_row = 0;
            end
            refill();
            stalled = bus_if.axis_TVALID && !bus_if.axis_TREADY;
            held    = bus_if.axis_TDATA;
            tick();
            if (stalled) begin
                check_eq("stall_hold", bus_if.axis_TDATA, held);
                check_eq("stall_valid", XW'(bus_if.axis_TVALID), XW'(1'b1));
            end
        end
        bus_if.evrHbMarker = 1'b0;
        bus_if.axis_TREADY = 1'b1;
        check_eq("beat_count_ok", XW'(n_beats > ncyc / 2), XW'(1'b1));
    endtask

    initial begin
        bus_if.sysGpioData      = 32'h0;
        bus_if.sysGpioStrobe    = 1'b0;
        bus_if.sysAddressStrobe = 1'b0;
        bus_if.evrHbMarker      = 1'b0;
        bus_if.axis_TREADY      = 1'b1;
        sysRst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_csr", XW'(bus_if.sysGpioCsr), XW'(32'h0));
        check_eq("rst_tvalid", XW'(bus_if.axis_TVALID), XW'(1'b0));
        check_eq("rst_tdata", bus_if.axis_TDATA, XW'(1'b0));
        sysRst_n = 1'b1;
        tick();

        // table = address, full 128 entries
        for (int a = 0; a < 128; a++) tbl_write(a, DW'(a));
        check_eq("csr_filled", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7F00));
        csr_write(32'h8000_0001);
        check_eq("csr_run", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7F01));
        start_stream();
        run_stream(40, 0, 0);
        check_eq("csr_synced", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7F03));

        // backpressure, then heartbeat during a stall, then heartbeat on a handshake
        run_stream(200, 16, 0);
        run_stream(300, 16, 128);
        run_stream(300, 0, 128);

        // stop
        csr_write(32'h8000_0000);
        check_eq("stop_tvalid", XW'(bus_if.axis_TVALID), XW'(1'b0));
        check_eq("stop_tdata", bus_if.axis_TDATA, XW'(1'b0));
        check_eq("stop_csr", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7F00));
        tick();
        check_eq("stop_tvalid2", XW'(bus_if.axis_TVALID), XW'(1'b0));

        // partial last row: lastIndex = 120
        for (int a = 0; a <= 120; a++) tbl_write(a, DW'(a) ^ 16'hA500);
        check_eq("csr_li120", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7800));
        csr_write(32'h8000_0001);
        start_stream();
        run_stream(60, 0, 0);
        check_eq("csr_li120_sync", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7803));

        // reset mid-stream
        bus_if.axis_TREADY = 1'b1;
        sysRst_n = 1'b0;
        tick();
        check_eq("mid_rst_csr", XW'(bus_if.sysGpioCsr), XW'(32'h0));
        check_eq("mid_rst_tvalid", XW'(bus_if.axis_TVALID), XW'(1'b0));
        check_eq("mid_rst_tdata", bus_if.axis_TDATA, XW'(1'b0));
        sysRst_n = 1'b1;
        model_last = 0;
        tick();
        check_eq("post_rst_tvalid", XW'(bus_if.axis_TVALID), XW'(1'b0));
        tbl_write(127, model_mem[127]);
        csr_write(32'h8000_0001);
        check_eq("post_rst_csr", XW'(bus_if.sysGpioCsr), XW'(32'h0000_7F01));
        start_stream();
        run_stream(60, 16, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/generic_dac_streamer.md
GENERIC_DAC_STREAMER -- requirements
Module: generic_dac_streamer

Interface
REQ-001 SHALL have parameters (name, default, meaning): BUS_WIDTH, 32, CSR bus width; AXIS_DATA_WIDTH, 256, stream beat width; DAC_DATA_WIDTH, 16, sample width; DAC_ADDRESS_WIDTH, 14, table address width; SPC = AXIS_DATA_WIDTH/DAC_DATA_WIDTH, derived, samples per beat (16).
REQ-002 SHALL have one clock and a synchronous, active-low reset: sysClk in 1, sole clock, all logic on its rising edge; sysRst_n in 1, synchronous active-low reset.
REQ-003 SHALL have ports (name, direction, width, meaning): sysGpioData in BUS_WIDTH, CSR write data; sysGpioStrobe in 1, CSR write strobe; sysAddressStrobe in 1, address-register write strobe; sysGpioCsr out BUS_WIDTH, status readback; evrHbMarker in 1, single-cycle heartbeat pulse; axis_TDATA out AXIS_DATA_WIDTH; axis_TVALID out 1; axis_TREADY in 1.

Function
REQ-004 SHALL latch sysGpioData[DAC_ADDRESS_WIDTH-1:0] into the address register on sysAddressStrobe.
REQ-005 On sysGpioStrobe with bit31=0 (address bank), SHALL write sysGpioData[DAC_DATA_WIDTH-1:0] to the table at the address register and set lastIndex to that address. Bits 30:DAC_DATA_WIDTH are ignored.
REQ-006 On sysGpioStrobe with bit31=1 (GPIO bank), SHALL set run to bit0; the table and lastIndex are unchanged.
REQ-007 sysGpioCsr SHALL read as {lastIndex zero-extended into bits 31:8, 6'b0, synced, run}, combinational from registers.
REQ-008 Table depth SHALL be 2^DAC_ADDRESS_WIDTH samples, organised as rows of SPC samples. Row r, sample k SHALL appear at axis_TDATA[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH]; the lowest address goes in the LSBs.
REQ-009 synced SHALL be set by the first evrHbMarker seen while run=1, and cleared when run=0.
REQ-010 axis_TVALID SHALL rise exactly 2 cycles after the synchronising heartbeat. The first beat SHALL be row 0.
REQ-011 The row pointer SHALL advance only on a TVALID&&TREADY handshake. After lastRow = lastIndex>>log2(SPC), it SHALL wrap to row 0.
REQ-012 If lastIndex is not row-aligned, the partial last row SHALL output whatever the table holds beyond lastIndex.
REQ-013 While TVALID=1 and TREADY=0, TDATA SHALL be held stable; no beat may be lost or duplicated.
REQ-014 A heartbeat while streaming SHALL set a pending resync. The beat after the next handshake SHALL be row 0.
REQ-015 A heartbeat coinciding with a handshake SHALL make the next beat row 0.
REQ-016 Clearing run SHALL drop TVALID and synced on the next cycle regardless of TREADY. While TVALID=0, TDATA SHALL be 0.
REQ-017 Table writes while streaming SHALL be permitted; they take effect the next time that row is read.

Reset
REQ-018 While sysRst_n=0 at a clock edge, the block SHALL clear run, synced, the address register, lastIndex, the row pointer, the resync flag, axis_TVALID and axis_TDATA. Table contents are not reset.
REQ-019 Reset mid-stream SHALL take priority over all strobes and heartbeats. Streaming SHALL resume only after run is set again and a new heartbeat arrives.

Structure
REQ-020 A shared package SHALL hold the CSR field constants: GPIO_BANK = 0x80000000, GPIO_RUN = 0x1, ADDRESS_MASK = 0x00FFFFFF, LAST_INDEX_MASK = 0xFFFFFF00, SYNCED = 0x2, RUN = 0x1. It SHALL also hold the default parameters.
REQ-021 The table SHALL be one sub-module, dac_table_ram: simple dual-port, DAC_DATA_WIDTH write port, SPC-wide row read port, 1-cycle registered read.

Verification
REQ-022 Fill table addresses 0..127 with value=address, set run, pulse heartbeat -> beat k carries samples 16k..16k+15 for k=0..7, then row 0 again; CSR reads 0x00007F03.
REQ-023 TREADY low one cycle in every 16 -> the accepted beat sequence is unchanged, and TDATA stays stable during each stall.
REQ-024 Heartbeat every 128 cycles while streaming -> the beat after the next handshake is row 0 (samples 0..15).
REQ-025 Write run=0 (0x80000000) -> TVALID=0 and TDATA=0 the next cycle; CSR bits 1:0 = 0; lastIndex retained (0x00007F00).
REQ-026 lastIndex=120 (fill 0..120) -> rows 0..7 stream, then wrap to row 0; CSR reads 0x00007803 while synced.
REQ-027 Assert sysRst_n=0 mid-stream -> sysGpioCsr=0 and TVALID=0; table data is intact after run is set and a heartbeat arrives.
